// File: rtl/pwm_fader_pkg.sv
// Shared definitions for the PWM duty fader: register map, FSM states, duty width.
package pwm_fader_pkg;

    localparam int DutyW = 8;

    localparam logic [1:0] AdrTarget  = 2'd0;
    localparam logic [1:0] AdrDiv     = 2'd1;
    localparam logic [1:0] AdrStatus  = 2'd2;
    localparam logic [1:0] AdrCurrent = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } fader_state_e;

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler: counts 0..Ticks-1 and pulses tick_o for one cycle
// each time the count wraps back to 0.
module tick_divider #(
    parameter int Ticks = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CntW = (Ticks > 1) ? $clog2(Ticks) : 1;
    localparam logic [CntW-1:0] Last = CntW'(Ticks - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;

    // Wrap the counter at Ticks-1; the tick lands in the cycle the count reads 0.
    always_comb begin
        cnt_d  = (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
        tick_d = (cnt_q == Last);
    end

    // Counter and tick registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/peri_pwm_fader.sv
// Wishbone-slave duty fader: ramps an 8-bit duty value one LSB per step toward a
// software target and pushes each new value to a PWM channel via a master write.
//
// state | meaning
// IDLE  | current == target, or a step just completed; load divcnt if work remains
// WAIT  | counting ticks down from DIV before the next step
// WRITE | master write of next in flight, held until m_ack_i
module peri_pwm_fader
    import pwm_fader_pkg::*;
#(
    parameter int ClkHz  = 0,
    parameter int StepHz = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [1:0]       wb_adr_i,
    input  logic [DutyW-1:0] wb_dat_i,
    output logic [DutyW-1:0] wb_dat_o,
    output logic             wb_ack_o,
    output logic             m_stb_o,
    output logic             m_we_o,
    output logic [DutyW-1:0] m_dat_o,
    input  logic             m_ack_i
);

    // Zero/undersized parameters collapse to a tick every clock rather than a divide fault.
    localparam int PrescaleRaw   = (StepHz > 0) ? ClkHz / ((StepHz > 0) ? StepHz : 1) : 1;
    localparam int PrescaleTicks = (PrescaleRaw >= 1) ? PrescaleRaw : 1;

    fader_state_e     state_q, state_d;
    logic [DutyW-1:0] target_q, target_d;
    logic [DutyW-1:0] div_q, div_d;
    logic [DutyW-1:0] current_q, current_d;
    logic [DutyW-1:0] next_q, next_d;
    logic [DutyW-1:0] divcnt_q, divcnt_d;
    logic             tick;
    logic             wb_wr;
    logic             busy;

    tick_divider #(
        .Ticks(PrescaleTicks)
    ) u_tick_divider (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tick_o(tick)
    );

    assign wb_wr    = wb_stb_i & wb_we_i;
    assign wb_ack_o = wb_stb_i;
    assign busy     = (state_q != IDLE) || (current_q != target_q);

    // Register writes and the step FSM; a target write and a master ack on the
    // same edge both land because they touch disjoint registers.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        div_d     = div_q;
        current_d = current_q;
        next_d    = next_q;
        divcnt_d  = divcnt_q;

        if (wb_wr) begin
            case (wb_adr_i)
                AdrTarget: target_d = wb_dat_i;
                AdrDiv:    div_d    = wb_dat_i;
                default:   ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (current_q != target_q) begin
                    divcnt_d = div_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (tick) begin
                    if (target_q == current_q) begin
                        state_d = IDLE;
                    end else if (divcnt_q == '0) begin
                        next_d  = (target_q > current_q) ? current_q + DutyW'(1)
                                                         : current_q - DutyW'(1);
                        state_d = WRITE;
                    end else begin
                        divcnt_d = divcnt_q - DutyW'(1);
                    end
                end
            end
            WRITE: begin
                if (m_ack_i) begin
                    current_d = next_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register file.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            target_q  <= '0;
            div_q     <= '0;
            current_q <= '0;
            next_q    <= '0;
            divcnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            div_q     <= div_d;
            current_q <= current_d;
            next_q    <= next_d;
            divcnt_q  <= divcnt_d;
        end
    end

    // Slave read mux.
    always_comb begin
        wb_dat_o = '0;
        case (wb_adr_i)
            AdrTarget:  wb_dat_o = target_q;
            AdrDiv:     wb_dat_o = div_q;
            AdrStatus:  wb_dat_o = {{(DutyW-1){1'b0}}, busy};
            AdrCurrent: wb_dat_o = current_q;
            default:    wb_dat_o = '0;
        endcase
    end

    // next_q keeps its value outside WRITE, so m_dat_o holds the last driven duty.
    assign m_stb_o = (state_q == WRITE);
    assign m_we_o  = m_stb_o;
    assign m_dat_o = next_q;

endmodule

// File: tb/tb_peri_pwm_fader.sv
// Directed bench for peri_pwm_fader: register table plus ramp/stall/reset sequences.
module tb_peri_pwm_fader;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       wb_stb_i = 1'b0;
    logic       wb_we_i = 1'b0;
    logic [1:0] wb_adr_i = 2'd0;
    logic [7:0] wb_dat_i = 8'd0;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;
    logic       m_stb_o;
    logic       m_we_o;
    logic [7:0] m_dat_o;
    logic       m_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int phase = 0;

    logic [7:0] wr_q[$];
    int         rise_q[$];
    logic       stb_prev = 1'b0;
    logic [7:0] rise_dat = 8'd0;

    typedef struct {
        logic       wr;
        logic [1:0] adr;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[14];

    peri_pwm_fader #(
        .ClkHz (8),
        .StepHz(2)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wb_stb_i(wb_stb_i),
        .wb_we_i (wb_we_i),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_dat_o (m_dat_o),
        .m_ack_i (m_ack_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Master-side monitor: logs strobe rises, completed writes, and data stability.
    always @(negedge clk_i) begin
        if (m_stb_o && !stb_prev) begin
            rise_q.push_back(cyc);
            rise_dat = m_dat_o;
        end
        if (m_stb_o) begin
            checks++;
            if (m_dat_o != rise_dat || m_we_o !== 1'b1) begin
                errors++;
                $display("FAIL m_stable: dat=%0d we=%0b required dat=%0d we=1", m_dat_o, m_we_o, rise_dat);
            end
        end
        if (m_stb_o && m_ack_i) wr_q.push_back(m_dat_o);
        stb_prev = m_stb_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [7:0] dat, output int w);
        @(posedge clk_i);
        #1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = adr;
        wb_dat_i = dat;
        @(posedge clk_i);
        #1;
        w = cyc;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] adr, output logic [7:0] d, output logic a);
        @(posedge clk_i);
        #1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = adr;
        #2;
        d = wb_dat_o;
        a = wb_ack_o;
        wb_stb_i = 1'b0;
    endtask

    task automatic read_check(input string nm, input logic [1:0] adr, input int exp);
        logic [7:0] d;
        logic       a;
        wb_read(adr, d, a);
        check(nm, int'(d), exp);
    endtask

    task automatic wait_writes(input string nm, input int n, input int budget);
        int k;
        k = 0;
        while (wr_q.size() < n && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        check(nm, (wr_q.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
    endtask

    task automatic clear_logs();
        wr_q.delete();
        rise_q.delete();
    endtask

    initial begin
        int w;
        int t;
        int r;
        logic [7:0] d;
        logic       a;

        vecs[0]  = '{1'b0, 2'd0, 8'd0,   8'd0};
        vecs[1]  = '{1'b0, 2'd1, 8'd0,   8'd0};
        vecs[2]  = '{1'b0, 2'd2, 8'd0,   8'd0};
        vecs[3]  = '{1'b0, 2'd3, 8'd0,   8'd0};
        vecs[4]  = '{1'b1, 2'd1, 8'd7,   8'd0};
        vecs[5]  = '{1'b0, 2'd1, 8'd0,   8'd7};
        vecs[6]  = '{1'b1, 2'd2, 8'hFF,  8'd0};
        vecs[7]  = '{1'b0, 2'd2, 8'd0,   8'd0};
        vecs[8]  = '{1'b1, 2'd3, 8'h55,  8'd0};
        vecs[9]  = '{1'b0, 2'd3, 8'd0,   8'd0};
        vecs[10] = '{1'b1, 2'd1, 8'd0,   8'd0};
        vecs[11] = '{1'b0, 2'd1, 8'd0,   8'd0};
        vecs[12] = '{1'b0, 2'd0, 8'd0,   8'd0};
        vecs[13] = '{1'b0, 2'd2, 8'd0,   8'd0};

        idle(3);
        #3 rst_i = 1'b0;
        check("reset_m_stb", int'(m_stb_o), 0);
        check("reset_m_dat", int'(m_dat_o), 0);

        // Register table (ack held low, target stays 0 so nothing ramps).
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                wb_write(vecs[i].adr, vecs[i].dat, w);
            end else begin
                wb_read(vecs[i].adr, d, a);
                check($sformatf("vec%0d_dat", i), int'(d), int'(vecs[i].exp));
                check($sformatf("vec%0d_ack", i), int'(a), 1);
            end
        end

        // Ramp up 0->3, DIV=0, ack tied high.
        m_ack_i = 1'b1;
        clear_logs();
        wb_write(2'd0, 8'd3, w);
        wait_writes("t1_done", 3, 100);
        idle(20);
        check("t1_count", wr_q.size(), 3);
        for (int i = 0; i < 3 && i < wr_q.size(); i++) check($sformatf("t1_val%0d", i), int'(wr_q[i]), i + 1);
        if (rise_q.size() >= 3) begin
            check("t1_first_early", (rise_q[0] >= w + 2) ? 1 : 0, 1);
            check("t1_first_late", (rise_q[0] <= w + 5) ? 1 : 0, 1);
            check("t1_space1", rise_q[1] - rise_q[0], 4);
            check("t1_space2", rise_q[2] - rise_q[1], 4);
            phase = rise_q[0] % 4;
        end else begin
            check("t1_rises", rise_q.size(), 3);
        end
        read_check("t1_current", 2'd3, 3);
        read_check("t1_status", 2'd2, 0);

        // Ramp down 3->0, no underflow.
        clear_logs();
        wb_write(2'd0, 8'd0, w);
        wait_writes("t2_done", 3, 100);
        idle(20);
        check("t2_count", wr_q.size(), 3);
        for (int i = 0; i < 3 && i < wr_q.size(); i++) check($sformatf("t2_val%0d", i), int'(wr_q[i]), 2 - i);
        if (rise_q.size() >= 1) check("t2_phase", rise_q[0] % 4, phase);
        read_check("t2_current", 2'd3, 0);
        read_check("t2_status", 2'd2, 0);

        // DIV=2, single step lands on the third tick after entering WAIT.
        wb_write(2'd1, 8'd2, w);
        clear_logs();
        wb_write(2'd0, 8'd1, w);
        t = w + 2;
        while (t % 4 != phase) t++;
        wait_writes("t3_done", 1, 100);
        idle(30);
        check("t3_count", wr_q.size(), 1);
        if (wr_q.size() >= 1) check("t3_val", int'(wr_q[0]), 1);
        if (rise_q.size() >= 1) check("t3_time", rise_q[0], t + 8);
        read_check("t3_current", 2'd3, 1);

        // Stalled ack: 5 cycles of strobe with stable data, then resume on next tick.
        wb_write(2'd1, 8'd0, w);
        @(posedge clk_i);
        #1 m_ack_i = 1'b0;
        clear_logs();
        wb_write(2'd0, 8'd3, w);
        t = 0;
        @(negedge clk_i);
        while (!m_stb_o && t < 40) begin
            @(negedge clk_i);
            t++;
        end
        check("t4_rise_seen", int'(m_stb_o), 1);
        r = cyc;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_stb%0d", i), int'(m_stb_o), 1);
            check($sformatf("t4_dat%0d", i), int'(m_dat_o), 2);
            @(posedge clk_i);
            #1;
            if (i < 4) @(negedge clk_i);
        end
        m_ack_i  = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 2'd3;
        #1;
        check("t4_current_before_ack", int'(wb_dat_o), 1);
        wb_stb_i = 1'b0;
        @(posedge clk_i);
        #1;
        wb_stb_i = 1'b1;
        wb_adr_i = 2'd3;
        #1;
        check("t4_current_after_ack", int'(wb_dat_o), 2);
        wb_stb_i = 1'b0;
        wait_writes("t4_done", 2, 100);
        idle(10);
        check("t4_count", wr_q.size(), 2);
        if (wr_q.size() >= 2) check("t4_val1", int'(wr_q[1]), 3);
        if (rise_q.size() >= 2) check("t4_next_rise", rise_q[1], r + 8);

        // Target rewritten to current while in WAIT: no write, back to idle.
        wb_write(2'd1, 8'd3, w);
        clear_logs();
        wb_write(2'd0, 8'd10, w);
        read_check("t5_busy", 2'd2, 1);
        wb_write(2'd0, 8'd3, w);
        idle(40);
        check("t5_no_write", rise_q.size(), 0);
        read_check("t5_status", 2'd2, 0);
        read_check("t5_current", 2'd3, 3);

        // Async reset in the middle of a stalled write.
        wb_write(2'd1, 8'd0, w);
        @(posedge clk_i);
        #1 m_ack_i = 1'b0;
        wb_write(2'd0, 8'd5, w);
        t = 0;
        @(negedge clk_i);
        while (!m_stb_o && t < 40) begin
            @(negedge clk_i);
            t++;
        end
        check("t6_in_write", int'(m_stb_o), 1);
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        check("t6_stb_drop", int'(m_stb_o), 0);
        check("t6_dat_zero", int'(m_dat_o), 0);
        idle(2);
        #3 rst_i = 1'b0;
        for (int i = 0; i < 4; i++) read_check($sformatf("t6_reg%0d", i), 2'(i), 0);
        m_ack_i = 1'b1;
        clear_logs();
        wb_write(2'd0, 8'd1, w);
        wait_writes("t6_done", 1, 100);
        idle(20);
        check("t6_count", wr_q.size(), 1);
        if (wr_q.size() >= 1) check("t6_val", int'(wr_q[0]), 1);
        read_check("t6_current", 2'd3, 1);
        read_check("t6_status", 2'd2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
